// File: rtl/muon_decay_timer_pkg.sv
// Shared types for the muon decay timer: ADC sample width, FSM states, FIFO entry record.
// The entry's dt field is DT_W_DEF bits wide; the top casts its counter into it.
package muon_pkg;
    localparam int ADC_W    = 14;
    localparam int DT_W_DEF = 16;

    typedef logic [ADC_W-1:0] adc_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    typedef struct packed {
        logic [DT_W_DEF-1:0] dt;
        adc_t                amp1;
        adc_t                amp2;
    } entry_t;
endpackage

// File: rtl/muon_decay_timer_if.sv
// Control, trigger/sample inputs and result-FIFO outputs of the decay timer.
// master drives stimulus and pops; slave is the timer itself.
interface muon_decay_timer_if import muon_pkg::*; #(
    parameter int DT_W = DT_W_DEF
) ();
    logic            enable;
    logic            trig_in;
    adc_t            adc_dat_in;
    logic [DT_W-1:0] holdoff;
    logic [DT_W-1:0] window;
    logic            rd_en;
    logic [DT_W-1:0] dt_out;
    adc_t            amp1_out;
    adc_t            amp2_out;
    logic            empty;
    logic            full;
    logic            overflow;
    logic [31:0]     n_timeout;
    logic            busy;

    modport master (
        output enable, trig_in, adc_dat_in, holdoff, window, rd_en,
        input  dt_out, amp1_out, amp2_out, empty, full, overflow, n_timeout, busy
    );

    modport slave (
        input  enable, trig_in, adc_dat_in, holdoff, window, rd_en,
        output dt_out, amp1_out, amp2_out, empty, full, overflow, n_timeout, busy
    );
endinterface

// File: rtl/muon_decay_timer_event_fifo.sv
// First-word fall-through FIFO; a write appears at the head one cycle after its edge.
// A write when full is dropped (o_drop) unless a pop happens on the same edge.
module event_fifo #(
    parameter int W  = 44,
    parameter int AW = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_dat,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_dat,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_drop
);
    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign w_pop    = i_rd_en & ~o_empty;
    assign w_push   = i_wr_en & (~o_full | w_pop);
    assign o_drop   = i_wr_en & o_full & ~w_pop;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign o_rd_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/muon_decay_timer.sv
// Measures cycles between two trigger rising edges and queues {dt, amp1, amp2} results.
// Result visible one cycle after the second edge; a full FIFO drops results (sticky overflow).
module muon_decay_timer import muon_pkg::*; #(
    parameter int DT_W    = DT_W_DEF,
    parameter int FIFO_AW = 3
) (
    input  logic               adc_clk,
    input  logic               adc_rstn,
    muon_decay_timer_if.slave  bus
);
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_trig_d;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_cnt_nxt;
    adc_t            r_amp1;
    adc_t            w_amp1_nxt;
    logic            r_overflow;
    logic [31:0]     r_n_timeout;
    logic            w_rise;
    logic            w_push;
    logic            w_timeout;
    logic            w_drop;
    logic            w_empty;
    logic            w_full;
    entry_t          w_push_dat;
    entry_t          w_head;

    assign w_rise = bus.trig_in & ~r_trig_d;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_amp1_nxt  = r_amp1;
        w_push      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable && w_rise) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = DT_W'(1);
                    w_amp1_nxt  = bus.adc_dat_in;
                end
            end
            ST_ARMED: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise && (r_cnt >= bus.holdoff)) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if ((r_cnt == bus.window) || (r_cnt == '1)) begin
                    // Saturated count also ends the event, covering window == 0.
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push_dat      = '0;
        w_push_dat.dt   = DT_W_DEF'(r_cnt);
        w_push_dat.amp1 = r_amp1;
        w_push_dat.amp2 = bus.adc_dat_in;
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            r_state     <= ST_IDLE;
            r_trig_d    <= 1'b1;
            r_cnt       <= '0;
            r_amp1      <= '0;
            r_overflow  <= 1'b0;
            r_n_timeout <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_d <= bus.trig_in;
            r_cnt    <= w_cnt_nxt;
            r_amp1   <= w_amp1_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_timeout && (r_n_timeout != '1)) begin
                r_n_timeout <= r_n_timeout + 32'd1;
            end
        end
    end

    event_fifo #(
        .W  ($bits(entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk    (adc_clk),
        .i_rst_n  (adc_rstn),
        .i_wr_en  (w_push),
        .i_wr_dat (w_push_dat),
        .i_rd_en  (bus.rd_en),
        .o_rd_dat (w_head),
        .o_empty  (w_empty),
        .o_full   (w_full),
        .o_drop   (w_drop)
    );

    assign bus.dt_out    = DT_W'(w_head.dt);
    assign bus.amp1_out  = w_head.amp1;
    assign bus.amp2_out  = w_head.amp2;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.n_timeout = r_n_timeout;
    assign bus.busy      = (r_state == ST_ARMED);
endmodule

// File: tb/tb_muon_decay_timer.sv
// Bench for muon_decay_timer: directed scenarios plus randomized traffic,
// checked every cycle against an elapsed-time/queue reference model.
module tb_muon_decay_timer;
    logic adc_clk  = 1'b0;
    logic adc_rstn = 1'b0;

    muon_decay_timer_if #(.DT_W(16)) bus ();

    muon_decay_timer #(.DT_W(16), .FIFO_AW(3)) dut (
        .adc_clk  (adc_clk),
        .adc_rstn (adc_rstn),
        .bus      (bus)
    );

    always #5 adc_clk = ~adc_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an event is a start cycle plus amp1; dt is elapsed cycles.
    typedef struct { int dt; int a1; int a2; } ent_t;
    ent_t    m_q[$];
    bit      m_armed = 0;
    longint  m_start = 0;
    longint  m_cyc   = 0;
    int      m_a1    = 0;
    bit      m_trigd = 1;
    bit      m_ovf   = 0;
    longint  m_nto   = 0;

    always @(posedge adc_clk or negedge adc_rstn) begin
        bit     rise, acc, pop, full_pre;
        longint el;
        ent_t   e;
        if (!adc_rstn) begin
            m_armed = 0;
            m_trigd = 1;
            m_ovf   = 0;
            m_nto   = 0;
            m_q.delete();
        end else begin
            m_cyc++;
            rise    = bus.trig_in && !m_trigd;
            m_trigd = bus.trig_in;
            acc     = 0;
            e       = '{0, 0, 0};
            if (!m_armed) begin
                if (bus.enable && rise) begin
                    m_armed = 1;
                    m_start = m_cyc;
                    m_a1    = int'(bus.adc_dat_in);
                end
            end else begin
                el = m_cyc - m_start;
                if (!bus.enable) begin
                    m_armed = 0;
                end else if (rise && el >= longint'(bus.holdoff)) begin
                    acc     = 1;
                    e       = '{int'(el), m_a1, int'(bus.adc_dat_in)};
                    m_armed = 0;
                end else if (el == longint'(bus.window) || el == 65535) begin
                    m_armed = 0;
                    if (m_nto < 64'hFFFF_FFFF) m_nto++;
                end
            end
            full_pre = (m_q.size() == 8);
            pop      = bus.rd_en && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                if (!full_pre || pop) m_q.push_back(e);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge adc_clk) begin
        chk("busy", bus.busy, m_armed);
        chk("empty", bus.empty, m_q.size() == 0);
        chk("full", bus.full, m_q.size() == 8);
        chk("overflow", bus.overflow, m_ovf);
        chk("n_timeout", bus.n_timeout, m_nto);
        if (m_q.size() > 0) begin
            chk("dt_out", bus.dt_out, m_q[0].dt);
            chk("amp1_out", bus.amp1_out, m_q[0].a1);
            chk("amp2_out", bus.amp2_out, m_q[0].a2);
        end else begin
            chk("dt_out_idle", bus.dt_out, 0);
            chk("amp_idle", {bus.amp1_out, bus.amp2_out}, 0);
        end
    end

    task automatic tick(input bit trig, input int dat, input bit rd);
        bus.trig_in    = trig;
        bus.adc_dat_in = 14'(dat);
        bus.rd_en      = rd;
        @(negedge adc_clk);
    endtask

    task automatic gap(input int n);
        repeat (n) tick(0, 0, 0);
    endtask

    task automatic do_reset();
        bus.trig_in = 0;
        bus.rd_en   = 0;
        #2 adc_rstn = 0;
        @(negedge adc_clk);
        #2 adc_rstn = 1;
        @(negedge adc_clk);
    endtask

    // Rises at i=0 and i=sep give dt = sep; rd applies on the second-edge cycle.
    task automatic event_pair(input int a1, input int sep, input int a2, input bit rd);
        tick(1, a1, 0);
        gap(sep - 1);
        tick(1, a2, rd);
        tick(0, 0, 0);
    endtask

    initial begin
        int busy_n;
        int rdp;
        bus.enable     = 1;
        bus.trig_in    = 0;
        bus.adc_dat_in = 0;
        bus.holdoff    = 10;
        bus.window     = 1000;
        bus.rd_en      = 0;
        @(negedge adc_clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        do_reset();

        // Basic pair: dt=250, entry appears right after the accepting edge.
        gap(3);
        tick(1, 'h100, 0);
        gap(249);
        chk("s1_empty_before", bus.empty, 1);
        tick(1, 'h080, 0);
        chk("s1_empty_after", bus.empty, 0);
        chk("s1_dt", bus.dt_out, 250);
        chk("s1_amp1", bus.amp1_out, 'h100);
        chk("s1_amp2", bus.amp2_out, 'h080);
        chk("s1_model_dt", m_q[0].dt, 250);
        tick(0, 0, 1);
        chk("s1_popped", bus.empty, 1);

        // Ringing inside holdoff is ignored.
        do_reset();
        tick(1, 1, 0);
        gap(3);
        tick(1, 2, 0);
        gap(35);
        tick(1, 3, 0);
        tick(0, 0, 0);
        chk("s2_dt", bus.dt_out, 40);
        chk("s2_amp2", bus.amp2_out, 3);
        chk("s2_busy", bus.busy, 0);
        tick(0, 0, 1);

        // Timeout after window cycles.
        do_reset();
        bus.window = 100;
        tick(1, 5, 0);
        busy_n = int'(bus.busy);
        for (int i = 0; i < 120; i++) begin
            tick(0, 0, 0);
            busy_n += int'(bus.busy);
        end
        chk("s3_busy_cycles", busy_n, 100);
        chk("s3_ntimeout", bus.n_timeout, 1);
        chk("s3_empty", bus.empty, 1);

        // window < holdoff: second rise is too late to count and re-arms.
        do_reset();
        bus.holdoff = 20;
        bus.window  = 8;
        event_pair(1, 10, 2, 0);
        gap(10);
        chk("s3b_ntimeout", bus.n_timeout, 2);
        chk("s3b_empty", bus.empty, 1);

        // Fill without reading: ninth result dropped, order preserved.
        do_reset();
        bus.holdoff = 2;
        bus.window  = 1000;
        for (int k = 0; k < 9; k++) begin
            event_pair(k + 1, 5, k + 'h200, 0);
            if (k == 7) begin
                chk("s4_full8", bus.full, 1);
                chk("s4_ovf8", bus.overflow, 0);
            end
        end
        chk("s4_full", bus.full, 1);
        chk("s4_overflow", bus.overflow, 1);
        for (int k = 0; k < 8; k++) begin
            chk("s4_pop_amp1", bus.amp1_out, k + 1);
            chk("s4_pop_amp2", bus.amp2_out, k + 'h200);
            chk("s4_pop_dt", bus.dt_out, 5);
            tick(0, 0, 1);
        end
        chk("s4_drained", bus.empty, 1);
        chk("s4_ovf_sticky", bus.overflow, 1);

        // Full FIFO with a pop on the accepting edge: no drop.
        do_reset();
        for (int k = 0; k < 8; k++) event_pair(k + 1, 5, k + 'h200, 0);
        event_pair('h11, 5, 'h22, 1);
        chk("s5_full", bus.full, 1);
        chk("s5_ovf", bus.overflow, 0);
        chk("s5_head", bus.amp1_out, 2);

        // Enable low mid-event returns to IDLE without a push.
        do_reset();
        bus.holdoff = 2;
        tick(1, 9, 0);
        gap(5);
        bus.enable = 0;
        tick(0, 0, 0);
        chk("s6_en_idle", bus.busy, 0);
        tick(1, 9, 0);
        bus.enable = 1;
        gap(3);
        chk("s6_no_push", bus.empty, 1);

        // Reset mid-event at cnt=50, then a normal pair.
        do_reset();
        bus.holdoff = 10;
        tick(1, 7, 0);
        gap(49);
        #2 adc_rstn = 0;
        #1;
        chk("s7_busy", bus.busy, 0);
        chk("s7_empty", bus.empty, 1);
        chk("s7_dt", bus.dt_out, 0);
        chk("s7_amp1", bus.amp1_out, 0);
        @(negedge adc_clk);
        #2 adc_rstn = 1;
        @(negedge adc_clk);
        event_pair('h33, 20, 'h44, 0);
        chk("s7_dt_after", bus.dt_out, 20);
        chk("s7_amp1_after", bus.amp1_out, 'h33);

        // Randomized traffic.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            bus.holdoff = 16'($urandom_range(0, 20));
            bus.window  = 16'($urandom_range(1, 80));
            rdp = (blk % 2 == 1) ? 3 : 20;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 499) == 0) do_reset();
                bus.enable = ($urandom_range(0, 15) != 0);
                tick($urandom_range(0, 3) == 0, int'($urandom_range(0, 16383)),
                     $urandom_range(0, rdp) == 0);
            end
        end
        bus.enable = 1;
        gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/muon_decay_timer.md
MUON_DECAY_TIMER -- requirements
Module: muon_decay_timer

Interface
REQ-001 Parameter DT_W, default 16, width of the decay-time counter and result.
REQ-002 Parameter FIFO_AW, default 3, result-FIFO address width (depth 2**FIFO_AW = 8).
REQ-003 adc_clk  input  1  sole clock, all logic on its rising edge.
REQ-004 adc_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  run enable; low forces IDLE and blocks FIFO writes.
REQ-006 trig_in  input  1  per-cycle threshold-comparator level from the upstream trigger stage.
REQ-007 adc_dat_in  input  14  registered ADC sample, aligned with trig_in.
REQ-008 holdoff  input  DT_W  minimum accepted separation in cycles; suppresses pulse ringing.
REQ-009 window  input  DT_W  maximum decay window in cycles.
REQ-010 rd_en  input  1  FIFO pop request.
REQ-011 dt_out  output  DT_W  head-of-FIFO decay time in cycles.
REQ-012 amp1_out, amp2_out  output  14 each  head-of-FIFO samples at first and second edge.
REQ-013 empty, full  output  1 each  FIFO status.
REQ-014 overflow  output  1  sticky; set when a result is dropped.
REQ-015 n_timeout  output  32  saturating count of first pulses with no second pulse in window.
REQ-016 busy  output  1  high when not IDLE.

Function
REQ-017 Edge detect: rise = trig_in & ~trig_d, where trig_d is trig_in registered; trig_d resets to 1 so a reset release with trig_in high is no edge.
REQ-018 FSM states: IDLE, ARMED.
REQ-019 IDLE, rise and enable: go to ARMED, cnt <= 1, amp1 <= adc_dat_in.
REQ-020 ARMED, rise and cnt >= holdoff: push {cnt, amp1, adc_dat_in} to the FIFO, then go to IDLE; dt equals cycles between the two edge cycles (adjacent edges give dt = 1).
REQ-021 ARMED, rise and cnt < holdoff: ignore the edge; cnt keeps incrementing.
REQ-022 ARMED, no accepted rise and cnt == window: go to IDLE, n_timeout += 1 (saturating at 2**32-1), nothing pushed.
REQ-023 ARMED otherwise: cnt <= cnt + 1; cnt never wraps, because window bounds it.
REQ-024 window == 0 or window < holdoff: every first pulse times out, at cnt == window or when cnt reaches 2**DT_W-1.
REQ-025 A second edge that ends an event does not start a new event in the same cycle; the next rise in IDLE does.
REQ-026 enable low: FSM goes to IDLE next cycle, cnt is held, no push; FIFO reads continue.
REQ-027 FIFO: synchronous, first-word fall-through; outputs show the head entry whenever empty = 0; rd_en with empty = 1 is ignored.
REQ-028 Push with full = 1: data dropped, overflow <= 1.
REQ-029 Simultaneous push and pop when full: pop succeeds and the push is accepted; occupancy is unchanged and overflow is not set.
REQ-030 Push latency: entry visible (empty falls) on the cycle after the accepting edge.

Reset
REQ-031 adc_rstn low asynchronously sets: state IDLE, cnt 0, amp regs 0, trig_d 1, FIFO pointers 0, empty 1, full 0, overflow 0, n_timeout 0, busy 0, dt_out/amp outputs 0.
REQ-032 Reset mid-event discards the event in progress; no partial entry enters the FIFO.
REQ-033 overflow and n_timeout clear only on reset.

Structure
REQ-034 Shared package muon_pkg holds ADC_W = 14, the state enum, and the FIFO entry record {dt, amp1, amp2}.
REQ-035 The FIFO is the sub-module event_fifo (parameterised width and depth, full/empty flags); the FSM and counters stay in the top module.

Verification
REQ-036 holdoff=10, window=1000; rises at t and t+250 with samples 0x100/0x080 -> one entry dt=250, amp1=0x100, amp2=0x080.
REQ-037 holdoff=10; rises at t, t+4, t+40 -> the t+4 rise is ignored; one entry dt=40.
REQ-038 window=100; single rise and no second -> busy for 100 cycles, then IDLE; n_timeout=1; empty stays 1.
REQ-039 rd_en=0; nine accepted events -> full after 8, ninth dropped, overflow=1; eight pops return entries in order.
REQ-040 adc_rstn pulsed low at cnt=50 -> immediate IDLE, all outputs at reset values, no entry; a following valid pair is recorded normally.
REQ-041 FIFO full, rd_en=1 during an accepted push -> occupancy stays 8, overflow stays 0.
